// File: rtl/dealer_player_port_if.sv
// dealer_player_port_if: byte link between one dealer seat and its player
interface dealer_player_port_if;
  logic [7:0] pl_data;
  logic       pl_cash_or_card;
  logic       pl_ack;
  logic [7:0] pl_data_in;
  logic       pl_ackin;
  logic       pl_fold;
  modport master (output pl_data, pl_cash_or_card, pl_ack, input pl_data_in, pl_ackin, pl_fold);
  modport slave (input pl_data, pl_cash_or_card, pl_ack, output pl_data_in, pl_ackin, pl_fold);
endinterface

// File: rtl/dealer_player_port.sv
// dealer_player_port: dealer-side seat endpoint that deals, takes the bet, serves swaps and audits the hand
module dealer_player_port #(
  parameter int TIMEOUT = 255,
  parameter int TW = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        game_over,
  input  logic [7:0]  chip_amount,
  output logic        card_req,
  input  logic        card_valid,
  input  logic [5:0]  card_data,
  dealer_player_port_if.master pl,
  output logic [7:0]  bet,
  output logic [2:0]  swap_count,
  output logic [29:0] hand,
  output logic        hand_valid,
  output logic        cheat,
  output logic        folded,
  output logic        timed_out,
  output logic        done,
  output logic        busy
);
  typedef enum logic [3:0] {IDLE, FETCH, DEAL, BET, SWAPQ, IDXQ, SWAPCARD, COLLECT, FIN} state_t;
  state_t state_q, state_d;
  logic wait_q, wait_d, swapping_q, swapping_d;
  logic [2:0] k_q, k_d, rem_q, rem_d, swaps_q, swaps_d;
  logic [4:0][5:0] rec_q, rec_d;
  logic [7:0] chips_q, chips_d, bet_q, bet_d;
  logic [29:0] hand_q, hand_d;
  logic cheat_q, cheat_d, folded_q, folded_d, to_q, to_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic xact, resp, expire, hit;
  logic [2:0] req;
  assign xact = state_q inside {DEAL, BET, SWAPQ, IDXQ, SWAPCARD, COLLECT};
  assign resp = xact && wait_q && pl.pl_ackin;
  assign expire = xact && wait_q && !pl.pl_ackin && cnt_q == TW'(TIMEOUT - 1);
  assign req = pl.pl_data_in[2:0] > 3'd4 ? 3'd4 : pl.pl_data_in[2:0];
  assign card_req = state_q == FETCH && !game_over;
  assign pl.pl_ack = xact && !wait_q && !game_over;
  assign pl.pl_cash_or_card = state_q inside {BET, SWAPQ, COLLECT};
  assign pl.pl_data = (state_q == DEAL || state_q == SWAPCARD) ? {2'b00, rec_q[k_q]} : state_q == BET ? chips_q : 8'h00;
  assign done = state_q == FIN && !game_over;
  assign hand_valid = done && !folded_q;
  assign busy = state_q != IDLE;
  assign bet = bet_q;
  assign swap_count = swaps_q;
  assign hand = hand_q;
  assign cheat = cheat_q;
  assign folded = folded_q;
  assign timed_out = to_q;
  // returned card is legitimate if it matches any slot of the dealer record
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 5; i++) hit = hit | (rec_q[i] == pl.pl_data_in[5:0]);
  end
  // next-state: abort beats fold beats timeout beats normal sequencing
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    swapping_d = swapping_q;
    k_d = k_q;
    rem_d = rem_q;
    swaps_d = swaps_q;
    rec_d = rec_q;
    chips_d = chips_q;
    bet_d = bet_q;
    hand_d = hand_q;
    cheat_d = cheat_q;
    folded_d = folded_q;
    to_d = to_q;
    cnt_d = cnt_q;
    if (game_over) begin
      state_d = IDLE;
      wait_d = 1'b0;
    end else if (resp && pl.pl_fold) begin
      folded_d = 1'b1;
      state_d = FIN;
      wait_d = 1'b0;
    end else if (expire) begin
      folded_d = 1'b1;
      to_d = 1'b1;
      state_d = FIN;
      wait_d = 1'b0;
    end else begin
      if (xact && !wait_q) begin
        wait_d = 1'b1;
        cnt_d = '0;
      end else if (xact) cnt_d = cnt_q + 1'b1;
      if (resp) wait_d = 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_d = FETCH;
          {swapping_d, k_d, rem_d, swaps_d, rec_d, bet_d, hand_d, cheat_d, folded_d, to_d} = '0;
          chips_d = chip_amount;
        end
        FETCH: if (card_valid) begin
          rec_d[k_q] = card_data;
          state_d = swapping_q ? SWAPCARD : DEAL;
        end
        DEAL: if (resp) begin
          k_d = k_q + 3'd1;
          state_d = k_q == 3'd4 ? BET : FETCH;
        end
        BET: if (resp) begin
          bet_d = pl.pl_data_in < chips_q ? pl.pl_data_in : chips_q;
          state_d = SWAPQ;
        end
        SWAPQ: if (resp) begin
          rem_d = req;
          swapping_d = 1'b1;
          k_d = 3'd0;
          state_d = req == 3'd0 ? COLLECT : IDXQ;
        end
        IDXQ: if (resp) begin
          k_d = req;
          state_d = FETCH;
        end
        SWAPCARD: if (resp) begin
          swaps_d = swaps_q + 3'd1;
          rem_d = rem_q - 3'd1;
          k_d = 3'd0;
          state_d = rem_q == 3'd1 ? COLLECT : IDXQ;
        end
        COLLECT: if (resp) begin
          hand_d = {hand_q[23:0], pl.pl_data_in[5:0]};
          cheat_d = cheat_q | !hit;
          k_d = k_q + 3'd1;
          state_d = k_q == 3'd4 ? FIN : COLLECT;
        end
        FIN: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // round state and FSM register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      {wait_q, swapping_q, k_q, rem_q, swaps_q, rec_q, chips_q, bet_q} <= '0;
      {hand_q, cheat_q, folded_q, to_q, cnt_q} <= '0;
    end else begin
      state_q <= state_d;
      {wait_q, swapping_q, k_q, rem_q, swaps_q, rec_q, chips_q, bet_q} <= {wait_d, swapping_d, k_d, rem_d, swaps_d, rec_d, chips_d, bet_d};
      {hand_q, cheat_q, folded_q, to_q, cnt_q} <= {hand_d, cheat_d, folded_d, to_d, cnt_d};
    end
  end
endmodule
